fib_req_scheduler: RTL and testbench

//   Shared Fibonacci compute engine serving NUM_REQ requesters. Round-robin arbiter

---
 rtl/fib_pkg.sv | 5 +
 rtl/fib_rr_arbiter.sv | 27 ++
 rtl/fib_req_scheduler.sv | 92 +++++++++
 tb/tb_fib_req_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding and constants for the Fibonacci request scheduler.
package fib_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} fib_state_t;
    localparam int FIB_MAX_IDX_32 = 47;
endpackage

// File: rtl/fib_rr_arbiter.sv
// fib_rr_arbiter: combinational round-robin pick; search starts one past last_grant.
module fib_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] id
);
    localparam int ID_W = $clog2(NUM_REQ);
    int   w_k;
    logic w_found;
    always_comb begin
        grant   = '0;
        id      = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = (int'(last_grant) + i) % NUM_REQ;
            if (!w_found && req[w_k]) begin
                w_found    = 1'b1;
                grant[w_k] = 1'b1;
                id         = ID_W'(w_k);
            end
        end
    end
endmodule

// File: rtl/fib_req_scheduler.sv
// fib_req_scheduler: round-robin shared Fibonacci engine; one iterative add per cycle,
// result returned over a valid/ready channel tagged with the requester id.
module fib_req_scheduler
    import fib_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*IDX_WIDTH-1:0] req_index,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_ovf,
    output logic                         busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    fib_state_t            r_state;
    logic [ID_W-1:0]       r_last, r_id, w_win;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_WIDTH-1:0]  r_cnt, w_idx;
    logic [DATA_WIDTH-1:0] r_a, r_b;
    logic                  r_ovf_a, r_ovf_b;
    logic [DATA_WIDTH:0]   w_sum;

    fib_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (r_last),
        .grant      (w_grant),
        .id         (w_win)
    );

    assign req_ready = (resetn && r_state == IDLE) ? w_grant : '0;
    assign w_idx     = req_index[w_win*IDX_WIDTH +: IDX_WIDTH];
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign busy      = r_state != IDLE;

    // ovf_a/ovf_b track whether the true value held in a/b has outgrown DATA_WIDTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_last    <= ID_W'(NUM_REQ - 1);
            r_id      <= '0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_ovf_a   <= 1'b0;
            r_ovf_b   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|req_ready) begin
                    r_id    <= w_win;
                    r_last  <= w_win;
                    r_cnt   <= w_idx;
                    r_a     <= '0;
                    r_b     <= DATA_WIDTH'(1);
                    r_ovf_a <= 1'b0;
                    r_ovf_b <= 1'b0;
                    r_state <= CALC;
                end
                CALC: if (r_cnt != '0) begin
                    r_a     <= r_b;
                    r_b     <= w_sum[DATA_WIDTH-1:0];
                    r_ovf_a <= r_ovf_b;
                    r_ovf_b <= r_ovf_b | r_ovf_a | w_sum[DATA_WIDTH];
                    r_cnt   <= r_cnt - 1'b1;
                end else begin
                    rsp_data  <= r_a;
                    rsp_ovf   <= r_ovf_a;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_req_scheduler.sv
// tb_fib_req_scheduler: directed checks of arbitration, latency, overflow, stall and reset.
module tb_fib_req_scheduler;
    logic        clk = 0, resetn = 1, rsp_ready = 0;
    logic [3:0]  req_valid = 0;
    logic [23:0] req_index = 0;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ovf, busy;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    int total = 0, bad = 0;

    fib_req_scheduler dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_index(req_index),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        resetn = 0; req_valid = 0; rsp_ready = 0;
        @(negedge clk);
        resetn = 1;
    endtask

    // Issue one request, collect its response, and complete the handshake.
    task automatic req_rsp(input int k, input int idx, output logic [31:0] d,
                           output logic [1:0] id, output logic ov, output int lat);
        int n;
        lat = -1; d = 'x; id = 'x; ov = 'x;
        @(negedge clk);
        req_valid[k] = 1;
        req_index[k*6 +: 6] = idx[5:0];
        #1;
        n = 0;
        while (!req_ready[k] && n < 300) begin @(negedge clk); #1; n++; end
        if (!req_ready[k]) begin req_valid[k] = 0; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 0;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        if (!rsp_valid) return;
        lat = n; d = rsp_data; id = rsp_id; ov = rsp_ovf;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        #2 resetn = 0; req_valid = 4'hf;
        #2;
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_data !== 32'd0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin bad++; $display("FAIL rst_rsp: got data=%0d id=%0d ovf=%b want 0 0 0", rsp_data, rsp_id, rsp_ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        resetn = 1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
        req_valid = 0;
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] id; logic ov; int lat;
        req_rsp(0, 10, d, id, ov, lat);
        total++; if (d !== 32'd55) begin bad++; $display("FAIL basic_data: got %0d want 55", d); end
        total++; if (id !== 2'd0 || ov !== 1'b0) begin bad++; $display("FAIL basic_id_ovf: got id=%0d ovf=%b want 0 0", id, ov); end
        total++; if (lat !== 11) begin bad++; $display("FAIL basic_latency: got %0d want 11", lat); end
    endtask

    task automatic test_sequence();
        int idx[4] = '{0, 1, 2, 20};
        logic [31:0] exp[4] = '{32'd0, 32'd1, 32'd1, 32'd6765};
        logic [31:0] d; logic [1:0] id; logic ov; int lat;
        for (int i = 0; i < 4; i++) begin
            req_rsp(1, idx[i], d, id, ov, lat);
            total++; if (d !== exp[i] || id !== 2'd1) begin bad++; $display("FAIL seq_data[%0d]: got %0d id=%0d want %0d id=1", idx[i], d, id, exp[i]); end
            total++; if (lat !== idx[i] + 1) begin bad++; $display("FAIL seq_latency[%0d]: got %0d want %0d", idx[i], lat, idx[i] + 1); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL seq_busy[%0d]: got %b want 0", idx[i], busy); end
        end
    endtask

    task automatic test_all_valid();
        int ord[5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;
        int n;
        do_reset();
        req_valid = 4'hf;
        req_index = {4{6'd5}};
        for (int g = 0; g < 5; g++) begin
            #1;
            n = 0;
            while (req_ready == 4'h0 && n < 300) begin @(negedge clk); #1; n++; end
            e = 4'(1 << ord[g]);
            total++; if (req_ready !== e) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", g, req_ready, e); end
            @(posedge clk);
            @(negedge clk);
            n = 0;
            while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd5 || rsp_id !== 2'(ord[g])) begin bad++; $display("FAIL rr_rsp[%0d]: got v=%b data=%0d id=%0d want 1 5 %0d", g, rsp_valid, rsp_data, rsp_id, ord[g]); end
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
        end
        req_valid = 0;
    endtask

    task automatic test_overflow();
        int idx[3] = '{47, 48, 63};
        logic [31:0] exp[3] = '{32'd2971215073, 32'd512559680, 32'd3350226146};
        logic eov[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] d; logic [1:0] id; logic ov; int lat;
        for (int i = 0; i < 3; i++) begin
            req_rsp(3, idx[i], d, id, ov, lat);
            total++; if (d !== exp[i] || ov !== eov[i]) begin bad++; $display("FAIL ovf[%0d]: got %0d ovf=%b want %0d ovf=%b", idx[i], d, ov, exp[i], eov[i]); end
            total++; if (lat !== idx[i] + 1 || id !== 2'd3) begin bad++; $display("FAIL ovf_lat_id[%0d]: got lat=%0d id=%0d want %0d 3", idx[i], lat, id, idx[i] + 1); end
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        req_valid = 4'b0100;
        req_index[12 +: 6] = 6'd3;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL stall_grant: got %b want 0100", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0010;
        req_index[6 +: 6] = 6'd4;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_id !== 2'd2 || rsp_ovf !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b data=%0d id=%0d ovf=%b want 1 2 2 0", c, rsp_valid, rsp_data, rsp_id, rsp_ovf); end
            total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, req_ready); end
        end
        rsp_ready = 1;
        #1;
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL stall_hs_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        rsp_ready = 0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin bad++; $display("FAIL stall_idle: got busy=%b v=%b ready=%b want 0 0 0010", busy, rsp_valid, req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_next_busy: got %b want 1", busy); end
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 2'd1) begin bad++; $display("FAIL stall_next_rsp: got v=%b data=%0d id=%0d want 1 3 1", rsp_valid, rsp_data, rsp_id); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_mid_reset();
        int n;
        logic seen;
        do_reset();
        req_valid = 4'b0001;
        req_index = {6'd0, 6'd0, 6'd7, 6'd30};
        #1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0011;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mr_busy_before: got %b want 1", busy); end
        resetn = 0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'h0) begin bad++; $display("FAIL mr_outputs: got busy=%b v=%b ready=%b want 0 0 0000", busy, rsp_valid, req_ready); end
        total++; if (rsp_data !== 32'd0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin bad++; $display("FAIL mr_rsp: got data=%0d id=%0d ovf=%b want 0 0 0", rsp_data, rsp_id, rsp_ovf); end
        req_valid = 0;
        @(negedge clk);
        resetn = 1;
        seen = 0;
        repeat (40) begin @(negedge clk); seen |= rsp_valid | busy; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mr_dropped: got activity=%b want 0", seen); end
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mr_grant0: got %b want 0001", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd832040 || rsp_id !== 2'd0) begin bad++; $display("FAIL mr_rsp0: got v=%b data=%0d id=%0d want 1 832040 0", rsp_valid, rsp_data, rsp_id); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mr_grant1: got %b want 0010", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd13 || rsp_id !== 2'd1) begin bad++; $display("FAIL mr_rsp1: got v=%b data=%0d id=%0d want 1 13 1", rsp_valid, rsp_data, rsp_id); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_all_valid();
        test_overflow();
        test_stall();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
